// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer for the shared memory port.
// Requester 0 is instruction fetch (read-only), requester 1 is load/store.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we1_i,
    output logic        sel_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic        gnt0_o,
    output logic        gnt1_o,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] rdata_o,
    output logic        done0_o,
    output logic        done1_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              wr_q, wr_d;
    logic              sel_q, sel_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              winner_s;

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        wr_d       = wr_q;
        sel_d      = sel_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        rdata_d    = rdata_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        // On a tie the requester that did not win last time goes next.
        winner_s   = (req0_i && req1_i) ? ~last_gnt_q : req1_i;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req0_i || req1_i) begin
                    state_d    = ST_ACCESS;
                    sel_d      = winner_s;
                    gnt0_d     = ~winner_s;
                    gnt1_d     = winner_s;
                    mem_en_d   = 1'b1;
                    mem_we_d   = winner_s & we1_i;
                    wr_d       = winner_s & we1_i;
                    last_gnt_d = winner_s;
                    cnt_d      = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                end
            end
            ST_ACCESS: begin
                cnt_d   = cnt_q - CNT_ONE;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter hits zero in the cycle the memory data is valid.
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_DONE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    if (!wr_q) begin
                        rdata_d = mem_rdata_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            last_gnt_q <= 1'b1;
            wr_q       <= 1'b0;
            sel_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            wr_q       <= wr_d;
            sel_q      <= sel_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rdata_q    <= rdata_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
        end
    end

    assign sel_o    = sel_q;
    assign mem_en_o = mem_en_q;
    assign mem_we_o = mem_we_q;
    assign gnt0_o   = gnt0_q;
    assign gnt1_o   = gnt1_q;
    assign rdata_o  = rdata_q;
    assign done0_o  = done0_q;
    assign done1_o  = done1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LATENCY=2 instance and a LATENCY=1 instance
// share inputs; per-cycle output vectors are compared against hand-derived values.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req0_i = 1'b0;
    logic        req1_i = 1'b0;
    logic        we1_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    logic        sel_a, en_a, we_a, g0_a, g1_a, d0_a, d1_a;
    logic [31:0] rdata_a;
    logic        sel_b, en_b, we_b, g0_b, g1_b, d0_b, d1_b;
    logic [31:0] rdata_b;

    int n_cmp = 0;
    int n_err = 0;

    // vector order: gnt0 gnt1 mem_en mem_we sel done0 done1
    wire [6:0] obs_a = {g0_a, g1_a, en_a, we_a, sel_a, d0_a, d1_a};
    wire [6:0] obs_b = {g0_b, g1_b, en_b, we_b, sel_b, d0_b, d1_b};

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.LATENCY(2), .CNT_W(4)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .req0_i(req0_i), .req1_i(req1_i), .we1_i(we1_i),
        .sel_o(sel_a), .mem_en_o(en_a), .mem_we_o(we_a), .gnt0_o(g0_a), .gnt1_o(g1_a),
        .mem_rdata_i(mem_rdata_i), .rdata_o(rdata_a), .done0_o(d0_a), .done1_o(d1_a)
    );

    mem_port_arbiter #(.LATENCY(1), .CNT_W(4)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .req0_i(req0_i), .req1_i(req1_i), .we1_i(we1_i),
        .sel_o(sel_b), .mem_en_o(en_b), .mem_we_o(we_b), .gnt0_o(g0_b), .gnt1_o(g1_b),
        .mem_rdata_i(mem_rdata_i), .rdata_o(rdata_b), .done0_o(d0_b), .done1_o(d1_b)
    );

    // Each task starts at a falling edge; inputs driven there are "cycle 0" inputs.
    task automatic test_reset();
        rst_i = 1'b0; req0_i = 1'b0; req1_i = 1'b0; we1_i = 1'b0;
        #1;
        n_cmp++;
        if (obs_a !== 7'b0 || rdata_a !== 32'h0) begin
            n_err++; $display("FAIL reset_a: got %b/%h want 0000000/00000000", obs_a, rdata_a);
        end
        n_cmp++;
        if (obs_b !== 7'b0 || rdata_b !== 32'h0) begin
            n_err++; $display("FAIL reset_b: got %b/%h want 0000000/00000000", obs_b, rdata_b);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_single_fetch();
        logic [6:0] exp_v [1:5];
        exp_v[1] = 7'b1010000; exp_v[2] = 7'b1000000; exp_v[3] = 7'b1000000;
        exp_v[4] = 7'b0000010; exp_v[5] = 7'b0000000;
        req0_i = 1'b1; mem_rdata_i = 32'h0BAD_0BAD;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs_a !== exp_v[c]) begin
                n_err++; $display("FAIL fetch c%0d: got %b want %b", c, obs_a, exp_v[c]);
            end
            if (c == 4) begin
                n_cmp++;
                if (rdata_a !== 32'hDEAD_BEEF) begin
                    n_err++; $display("FAIL fetch_rdata: got %h want deadbeef", rdata_a);
                end
                req0_i = 1'b0;
            end
            mem_rdata_i = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
        end
    endtask

    task automatic test_round_robin();
        logic [6:0] exp_v;
        int p, o;
        req0_i = 1'b1; req1_i = 1'b1; we1_i = 1'b0; mem_rdata_i = 32'hA000_0000;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk_i);
            p = (c - 1) / 4;
            o = (c - 1) % 4;
            exp_v = 7'b0;
            if (c == 17) begin
                exp_v = 7'b0000100;
            end else begin
                exp_v[2] = (p % 2 == 1);
                if (o < 3) exp_v[(p % 2 == 1) ? 5 : 6] = 1'b1;
                if (o == 0) exp_v[4] = 1'b1;
                if (o == 3) exp_v[(p % 2 == 1) ? 0 : 1] = 1'b1;
            end
            n_cmp++;
            if (obs_a !== exp_v) begin
                n_err++; $display("FAIL round_robin c%0d: got %b want %b", c, obs_a, exp_v);
            end
            if (o == 3 && c < 17) begin
                n_cmp++;
                if (rdata_a !== 32'hA000_0000 + 32'(c - 1)) begin
                    n_err++; $display("FAIL rr_rdata c%0d: got %h want %h", c, rdata_a,
                                      32'hA000_0000 + 32'(c - 1));
                end
            end
            if (c == 16) begin
                req0_i = 1'b0; req1_i = 1'b0;
            end
            mem_rdata_i = 32'hA000_0000 + 32'(c);
        end
    endtask

    task automatic test_write();
        logic [6:0] exp_v [1:5];
        exp_v[1] = 7'b0111100; exp_v[2] = 7'b0100100; exp_v[3] = 7'b0100100;
        exp_v[4] = 7'b0000101; exp_v[5] = 7'b0000100;
        req1_i = 1'b1; we1_i = 1'b1; mem_rdata_i = 32'h55AA_55AA;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs_a !== exp_v[c]) begin
                n_err++; $display("FAIL write c%0d: got %b want %b", c, obs_a, exp_v[c]);
            end
            n_cmp++;
            if (rdata_a !== 32'hA000_000F) begin
                n_err++; $display("FAIL write_rdata c%0d: got %h want a000000f", c, rdata_a);
            end
            we1_i = 1'b0;
            if (c == 4) req1_i = 1'b0;
        end
    endtask

    task automatic test_short_pulse();
        logic [6:0] exp_v [1:7];
        exp_v[1] = 7'b0110100; exp_v[2] = 7'b0100100; exp_v[3] = 7'b0100100;
        exp_v[4] = 7'b0000101; exp_v[5] = 7'b0000100; exp_v[6] = 7'b0000100;
        exp_v[7] = 7'b0000100;
        req1_i = 1'b1; we1_i = 1'b0; mem_rdata_i = 32'hC0DE_0000;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_i);
            req1_i = 1'b0;
            n_cmp++;
            if (obs_a !== exp_v[c]) begin
                n_err++; $display("FAIL short_pulse c%0d: got %b want %b", c, obs_a, exp_v[c]);
            end
            if (c == 4) begin
                n_cmp++;
                if (rdata_a !== 32'hC0DE_0003) begin
                    n_err++; $display("FAIL short_rdata: got %h want c0de0003", rdata_a);
                end
            end
            mem_rdata_i = 32'hC0DE_0000 + 32'(c);
        end
    endtask

    task automatic test_reset_mid_txn();
        logic [6:0] exp_v [1:5];
        exp_v[1] = 7'b1010000; exp_v[2] = 7'b1000000; exp_v[3] = 7'b1000000;
        exp_v[4] = 7'b0000010; exp_v[5] = 7'b0000000;
        req0_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (obs_a !== 7'b1000000) begin
            n_err++; $display("FAIL pre_reset_wait: got %b want 1000000", obs_a);
        end
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (obs_a !== 7'b0 || rdata_a !== 32'h0) begin
            n_err++; $display("FAIL async_reset: got %b/%h want 0000000/00000000", obs_a, rdata_a);
        end
        @(negedge clk_i);
        rst_i = 1'b1; req0_i = 1'b1; req1_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs_a !== exp_v[c]) begin
                n_err++; $display("FAIL post_reset c%0d: got %b want %b", c, obs_a, exp_v[c]);
            end
            if (c == 4) begin
                req0_i = 1'b0; req1_i = 1'b0;
            end
        end
    endtask

    task automatic test_latency1_back_to_back();
        logic [6:0] exp_v;
        int o;
        req0_i = 1'b1; mem_rdata_i = 32'hE000_0000;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            o = (c - 1) % 3;
            exp_v = 7'b0;
            if (c < 10) begin
                if (o == 0) exp_v = 7'b1010000;
                if (o == 1) exp_v = 7'b1000000;
                if (o == 2) exp_v = 7'b0000010;
            end
            n_cmp++;
            if (obs_b !== exp_v) begin
                n_err++; $display("FAIL lat1 c%0d: got %b want %b", c, obs_b, exp_v);
            end
            if (o == 2 && c < 10) begin
                n_cmp++;
                if (rdata_b !== 32'hE000_0000 + 32'(c - 1)) begin
                    n_err++; $display("FAIL lat1_rdata c%0d: got %h want %h", c, rdata_b,
                                      32'hE000_0000 + 32'(c - 1));
                end
            end
            if (c == 9) req0_i = 1'b0;
            mem_rdata_i = 32'hE000_0000 + 32'(c);
        end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_single_fetch();
        test_reset();
        test_round_robin();
        test_write();
        test_short_pulse();
        test_reset_mid_txn();
        test_reset();
        test_latency1_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
